mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 97 +++++++++
 tb/tb_mul_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequencer for an external N x N multiplier: accepts a request, gives the multiplier
// a fresh enable pulse of LAT cycles, captures the product and holds it until it is taken.
module mul_seq #(
  parameter int N   = 4,
  parameter int LAT = N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_y,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*N-1:0] rsp_p,
  output logic [7:0]     op_cnt
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  if (LAT < 1) begin : g_lat_check
    $error("mul_seq: LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          last;

  assign last      = (cnt == LAST);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ARM;
      ARM:     state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ARM keeps mul_start low for one cycle so the multiplier always sees a 0->1 enable edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      op_cnt    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mul_a <= req_a;
            mul_b <= req_b;
          end
        end
        ARM: begin
          mul_start <= 1'b1;
          cnt       <= '0;
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (last) begin
            rsp_p     <= mul_y;
            rsp_valid <= 1'b1;
            mul_start <= 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_cnt    <= op_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq (N=4, LAT=4) with a behavioural multiplier whose product
// is only valid once its enable has been high long enough.
module tb_mul_seq;
  localparam int N   = 4;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic         mul_start;
  logic [N-1:0] mul_a;
  logic [N-1:0] mul_b;
  logic [2*N-1:0] mul_y;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2*N-1:0] rsp_p;
  logic [7:0]   op_cnt;

  int pass_cnt = 0;
  int total    = 0;

  mul_seq #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier model: garbage until the enable has been high for LAT-1 edges.
  int en_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         en_cnt <= 0;
    else if (mul_start) en_cnt <= en_cnt + 1;
    else                en_cnt <= 0;
  end
  assign mul_y = (en_cnt >= LAT - 1) ? ({4'b0, mul_a} * {4'b0, mul_b}) : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for rsp_valid after the accepting edge; counts edges and enable-high cycles.
  task automatic wait_rsp(output int cyc, output int hi);
    cyc = 0;
    hi  = 0;
    while (!rsp_valid && cyc < 50) begin
      if (mul_start) hi++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #2;
    total++; if ({mul_start, mul_a, mul_b, rsp_valid, rsp_p, op_cnt} !== '0)
      $display("FAIL reset_outputs: got %h want 0", {mul_start, mul_a, mul_b, rsp_valid, rsp_p, op_cnt}); else pass_cnt++;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", req_ready); else pass_cnt++;
    total++; if (op_cnt !== 8'd0) $display("FAIL post_reset_op_cnt: got %0d want 0", op_cnt); else pass_cnt++;
  endtask

  task automatic test_basic();
    int cyc, hi;
    req_a = 4'd10; req_b = 4'd5; req_valid = 1'b1; rsp_ready = 1'b1;
    total++; if (req_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", req_ready); else pass_cnt++;
    tick();
    req_valid = 1'b0;
    total++; if (mul_a !== 4'd10 || mul_b !== 4'd5)
      $display("FAIL basic_operands: got %0d,%0d want 10,5", mul_a, mul_b); else pass_cnt++;
    total++; if (mul_start !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL basic_arm: got start=%b ready=%b want 0,0", mul_start, req_ready); else pass_cnt++;
    wait_rsp(cyc, hi);
    total++; if (cyc !== LAT + 1) $display("FAIL basic_latency: got %0d want %0d", cyc, LAT + 1); else pass_cnt++;
    total++; if (hi !== LAT) $display("FAIL basic_start_len: got %0d want %0d", hi, LAT); else pass_cnt++;
    total++; if (rsp_p !== 8'd50) $display("FAIL basic_product: got %0d want 50", rsp_p); else pass_cnt++;
    tick();
    total++; if (op_cnt !== 8'd1 || rsp_valid !== 1'b0)
      $display("FAIL basic_handshake: got cnt=%0d valid=%b want 1,0", op_cnt, rsp_valid); else pass_cnt++;
    total++; if (rsp_p !== 8'd50) $display("FAIL basic_retain: got %0d want 50", rsp_p); else pass_cnt++;
    total++; if (req_ready !== 1'b1) $display("FAIL basic_idle_ready: got %b want 1", req_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [3] = '{4'd2, 4'd3, 4'd15};
    logic [3:0] bv [3] = '{4'd2, 4'd2, 4'd14};
    logic [7:0] ev [3] = '{8'd4, 8'd6, 8'd210};
    int cyc, hi;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_a = av[i]; req_b = bv[i]; req_valid = 1'b1;
      total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", i, req_ready); else pass_cnt++;
      tick();
      total++; if (mul_start !== 1'b0) $display("FAIL b2b_arm_low%0d: got %b want 0", i, mul_start); else pass_cnt++;
      wait_rsp(cyc, hi);
      total++; if (rsp_p !== ev[i]) $display("FAIL b2b_product%0d: got %0d want %0d", i, rsp_p, ev[i]); else pass_cnt++;
      total++; if (hi !== LAT) $display("FAIL b2b_start_len%0d: got %0d want %0d", i, hi, LAT); else pass_cnt++;
      tick();
    end
    req_valid = 1'b0;
    total++; if (op_cnt !== 8'd4) $display("FAIL b2b_op_cnt: got %0d want 4", op_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int cyc, hi;
    rsp_ready = 1'b0; req_a = 4'd15; req_b = 4'd14; req_valid = 1'b1;
    tick();
    req_a = 4'd1; req_b = 4'd1;
    wait_rsp(cyc, hi);
    total++; if (rsp_p !== 8'd210) $display("FAIL bp_product: got %0d want 210", rsp_p); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_p !== 8'd210 || req_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b p=%0d ready=%b want 1,210,0", i, rsp_valid, rsp_p, req_ready); else pass_cnt++;
    end
    total++; if (op_cnt !== 8'd4) $display("FAIL bp_cnt_held: got %0d want 4", op_cnt); else pass_cnt++;
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    total++; if (op_cnt !== 8'd5 || rsp_valid !== 1'b0)
      $display("FAIL bp_release: got cnt=%0d valid=%b want 5,0", op_cnt, rsp_valid); else pass_cnt++;
    tick();
    total++; if (op_cnt !== 8'd5) $display("FAIL bp_single_inc: got %0d want 5", op_cnt); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_ignore_inputs();
    int cyc, hi;
    rsp_ready = 1'b0; req_a = 4'd6; req_b = 4'd7; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    req_a = 4'd9; req_b = 4'd9; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (mul_a !== 4'd6 || mul_b !== 4'd7)
      $display("FAIL ign_operands: got %0d,%0d want 6,7", mul_a, mul_b); else pass_cnt++;
    total++; if (op_cnt !== 8'd5 || rsp_valid !== 1'b0)
      $display("FAIL ign_no_rsp: got cnt=%0d valid=%b want 5,0", op_cnt, rsp_valid); else pass_cnt++;
    req_valid = 1'b0;
    wait_rsp(cyc, hi);
    total++; if (rsp_p !== 8'd42 || rsp_valid !== 1'b1)
      $display("FAIL ign_product: got p=%0d valid=%b want 42,1", rsp_p, rsp_valid); else pass_cnt++;
    rsp_ready = 1'b1;
    tick();
    total++; if (op_cnt !== 8'd6) $display("FAIL ign_handshake: got %0d want 6", op_cnt); else pass_cnt++;
    for (int i = 0; i < 5; i++) tick();
    total++; if (rsp_valid !== 1'b0 || op_cnt !== 8'd6)
      $display("FAIL ign_no_extra: got valid=%b cnt=%0d want 0,6", rsp_valid, op_cnt); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bit seen;
    rsp_ready = 1'b1; req_a = 4'd15; req_b = 4'd14; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({mul_start, mul_a, mul_b, rsp_valid, rsp_p, op_cnt} !== '0)
      $display("FAIL rst_mid_outputs: got %h want 0", {mul_start, mul_a, mul_b, rsp_valid, rsp_p, op_cnt}); else pass_cnt++;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", req_ready); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) $display("FAIL rst_mid_first_ready: got %b want 1", req_ready); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0 || op_cnt !== 8'd0)
      $display("FAIL rst_mid_discard: got seen=%b cnt=%0d want 0,0", seen, op_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int cyc, hi;
    rsp_ready = 1'b1; req_a = 4'd1; req_b = 4'd1;
    for (int i = 0; i < 255; i++) begin
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      wait_rsp(cyc, hi);
      tick();
    end
    total++; if (op_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", op_cnt); else pass_cnt++;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_rsp(cyc, hi);
    total++; if (rsp_valid !== 1'b1 || rsp_p !== 8'd1)
      $display("FAIL wrap_last_rsp: got valid=%b p=%0d want 1,1", rsp_valid, rsp_p); else pass_cnt++;
    tick();
    total++; if (op_cnt !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", op_cnt); else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_ignore_inputs();
    test_reset_midrun();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
